bitonic_seq_builder: RTL and testbench

- Serial-to-parallel front end that feeds the bitonic merge pipeline.
- Accepts a 16-bit signed sample stream over a valid/ready handshake. Each frame holds two pre-sorted runs of K/2 samples.
- Packs each frame into one K-lane word: run A in natural lane order, run B lane-reversed. The result is a bitonic sequence ready for merging.
- Checks run monotonicity per frame, tags frames, and double-buffers so a new frame loads while the previous one waits at the output.

---
 rtl/bitonic_seq_builder.sv | 220 ++++++++++++++++++++++
 tb/tb_bitonic_seq_builder.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitonic_seq_builder.sv
// -----------------------------------------------------------------------------
// bitonic_seq_builder
//
// Serial-to-parallel front end for the bitonic merge pipeline. A frame is K
// signed 16-bit samples made of two pre-sorted runs of K/2 samples each. Run A
// is packed into lanes 0..K/2-1 in arrival order. Run B is packed lane-reversed
// into lanes K-1..K/2. The packed word is therefore bitonic.
//
// Each run is checked for monotonicity in the direction set by SORTDIR. The
// result travels with the frame as m_err. Every emitted frame carries an 8-bit
// sequence tag. A load buffer and an output register form a two-deep pipeline,
// so the next frame can load while the previous one waits for m_ready.
//
// Parameters
//   K        lanes per frame (power of two, >= 2)
//   SORTDIR  0: runs must be non-decreasing, 1: runs must be non-increasing
//
// Ports
//   clk      clock
//   rst      asynchronous active-high reset
//   s_valid  input sample valid
//   s_ready  input can accept a sample (combinational)
//   s_data   signed input sample
//   m_valid  output frame valid (registered)
//   m_ready  downstream accepts the frame
//   m_data   packed frame, lane i at [i*16 +: 16] (registered)
//   m_err    monotonicity violation seen in the frame on m_data (registered)
//   m_tag    sequence number of the frame on m_data (registered)
// -----------------------------------------------------------------------------
module bitonic_seq_builder #(
  parameter int K       = 8,
  parameter bit SORTDIR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [15:0]       s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [K*16-1:0]   m_data,
  output logic              m_err,
  output logic [7:0]        m_tag
);

  localparam int            CW   = (K > 2) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);
  localparam logic [CW-1:0] HALF = CW'(K / 2);

  // Returns 1 when cur breaks the required run ordering with respect to prev.
  // Equal samples never count as a violation.
  function automatic logic order_violation(input logic signed [15:0] cur,
                                           input logic signed [15:0] prev);
    logic bad;
    if (SORTDIR) begin
      bad = (cur > prev);
    end else begin
      bad = (cur < prev);
    end
    return bad;
  endfunction

  // Frame assembly state
  logic [CW-1:0]            cnt_q,       cnt_d;
  logic                     load_full_q, load_full_d;
  logic signed [15:0]       prev_q,      prev_d;
  logic                     err_acc_q,   err_acc_d;
  logic                     load_err_q,  load_err_d;
  logic [K-1:0][15:0]       lbuf_q,      lbuf_d;

  // Output stage state
  logic [7:0]               tag_cnt_q,   tag_cnt_d;
  logic                     m_valid_q,   m_valid_d;
  logic [K*16-1:0]          m_data_q,    m_data_d;
  logic                     m_err_q,     m_err_d;
  logic [7:0]               m_tag_q,     m_tag_d;

  // Handshake and datapath helpers
  logic                     out_free_s;
  logic                     accept_s;
  logic                     xfer_s;
  logic                     last_s;
  logic                     run_start_s;
  logic                     viol_s;
  logic                     frame_err_s;
  logic [CW-1:0]            lane_s;

  // Handshake decode: the output register is free when empty or draining, and
  // the load buffer can take a sample unless it holds a frame that cannot move.
  always_comb begin
    out_free_s  = !m_valid_q || m_ready;
    s_ready     = !load_full_q || out_free_s;
    accept_s    = s_valid && s_ready;
    xfer_s      = load_full_q && out_free_s;
    last_s      = (cnt_q == LAST);
    run_start_s = (cnt_q == '0) || (cnt_q == HALF);
  end

  // Lane selection: run A lands in natural order, run B lands mirrored from
  // the top lane downwards (index j >= K/2 goes to lane K-1-(j-K/2)).
  always_comb begin
    if (cnt_q < HALF) begin
      lane_s = cnt_q;
    end else begin
      lane_s = LAST - (cnt_q - HALF);
    end
  end

  // Monotonicity check. The first sample of each run has nothing to compare
  // with, and no compare crosses the A/B run boundary.
  always_comb begin
    if (accept_s && !run_start_s) begin
      viol_s = order_violation($signed(s_data), prev_q);
    end else begin
      viol_s = 1'b0;
    end
    // Index 0 starts a fresh frame, so the accumulated flag from the previous
    // frame is ignored there.
    if (cnt_q == '0) begin
      frame_err_s = viol_s;
    end else begin
      frame_err_s = err_acc_q | viol_s;
    end
  end

  // Load-side next state: sample counter, lane write, error accumulation and
  // the load_full flag that hands a complete frame to the output stage.
  always_comb begin
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    err_acc_d   = err_acc_q;
    load_err_d  = load_err_q;
    lbuf_d      = lbuf_q;
    load_full_d = load_full_q;

    // The transfer reads lbuf_q, so a same-cycle write into lane 0 of the next
    // frame cannot corrupt the frame being moved out.
    if (xfer_s) begin
      load_full_d = 1'b0;
    end else begin
      load_full_d = load_full_q;
    end

    if (accept_s) begin
      lbuf_d[lane_s] = s_data;
      prev_d         = $signed(s_data);
      err_acc_d      = frame_err_s;
      if (last_s) begin
        cnt_d       = '0;
        load_full_d = 1'b1;
        load_err_d  = frame_err_s;
      end else begin
        cnt_d       = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output-side next state: capture a complete frame when the output register
  // is free, otherwise drop m_valid once it has been taken, otherwise hold.
  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_err_d   = m_err_q;
    m_tag_d   = m_tag_q;
    tag_cnt_d = tag_cnt_q;

    if (xfer_s) begin
      m_valid_d = 1'b1;
      m_data_d  = lbuf_q;
      m_err_d   = load_err_q;
      m_tag_d   = tag_cnt_q;
      tag_cnt_d = tag_cnt_q + 8'd1;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State registers with asynchronous reset; a reset mid-frame discards the
  // partial frame because cnt returns to 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      load_full_q <= 1'b0;
      prev_q      <= '0;
      err_acc_q   <= 1'b0;
      load_err_q  <= 1'b0;
      lbuf_q      <= '0;
      tag_cnt_q   <= 8'd0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_err_q     <= 1'b0;
      m_tag_q     <= 8'd0;
    end else begin
      cnt_q       <= cnt_d;
      load_full_q <= load_full_d;
      prev_q      <= prev_d;
      err_acc_q   <= err_acc_d;
      load_err_q  <= load_err_d;
      lbuf_q      <= lbuf_d;
      tag_cnt_q   <= tag_cnt_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_err_q     <= m_err_d;
      m_tag_q     <= m_tag_d;
    end
  end

  // Drive the registered outputs.
  always_comb begin
    m_valid = m_valid_q;
    m_data  = m_data_q;
    m_err   = m_err_q;
    m_tag   = m_tag_q;
  end

endmodule

// File: tb/tb_bitonic_seq_builder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for bitonic_seq_builder.
// dut0: K=8, SORTDIR=0, checked against a frame-level reference model and a
//       table of hand-computed vectors. dut1: K=8, SORTDIR=1, table vectors.
// -----------------------------------------------------------------------------
module tb_bitonic_seq_builder;

  localparam int K = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1, m_err;
  logic [15:0]      s_data = 16'd0;
  logic [K*16-1:0]  m_data;
  logic [7:0]       m_tag;

  logic             s_valid1 = 1'b0, s_ready1, m_valid1, m_ready1 = 1'b1, m_err1;
  logic [15:0]      s_data1 = 16'd0;
  logic [K*16-1:0]  m_data1;
  logic [7:0]       m_tag1;

  bitonic_seq_builder #(.K(K), .SORTDIR(1'b0)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_err(m_err), .m_tag(m_tag)
  );

  bitonic_seq_builder #(.K(K), .SORTDIR(1'b1)) dut1 (
    .clk(clk), .rst(rst), .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
    .m_valid(m_valid1), .m_ready(m_ready1), .m_data(m_data1), .m_err(m_err1), .m_tag(m_tag1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame level, SORTDIR=0) ----------------
  logic [15:0]  samp_q[$];
  logic [127:0] exp_data_q[$];
  logic         exp_err_q[$];
  logic [7:0]   exp_tag_q[$];
  logic [7:0]   model_tag;
  int           model_frames;

  logic         hold_pending;
  logic [127:0] hold_data;
  logic         hold_err;
  logic [7:0]   hold_tag;

  task automatic model_reset();
    samp_q.delete();
    exp_data_q.delete();
    exp_err_q.delete();
    exp_tag_q.delete();
    model_tag    = 8'd0;
    model_frames = 0;
    hold_pending = 1'b0;
  endtask

  task automatic model_push(input logic [15:0] d);
    logic [127:0] f;
    logic         e;
    samp_q.push_back(d);
    if (samp_q.size() == K) begin
      f = '0;
      e = 1'b0;
      for (int i = 0; i < K / 2; i++) f[i*16 +: 16] = samp_q[i];
      for (int t = 0; t < K / 2; t++) f[(K - 1 - t)*16 +: 16] = samp_q[K / 2 + t];
      for (int i = 1; i < K; i++) begin
        if (i != K / 2 && $signed(samp_q[i]) < $signed(samp_q[i - 1])) e = 1'b1;
      end
      exp_data_q.push_back(f);
      exp_err_q.push_back(e);
      exp_tag_q.push_back(model_tag);
      model_tag = model_tag + 8'd1;
      model_frames++;
      samp_q.delete();
    end
  endtask

  // One dut0 cycle: drive at negedge, observe 1 time unit later, the
  // following posedge consumes the handshake.
  task automatic cyc(input logic v, input logic [15:0] d, input logic mr, output logic acc);
    @(negedge clk);
    s_valid = v;
    s_data  = d;
    m_ready = mr;
    #1;
    if (hold_pending) begin
      check("hold_valid", 128'(m_valid), 128'(1'b1));
      check("hold_data", 128'(m_data), hold_data);
      check("hold_err", 128'(m_err), 128'(hold_err));
      check("hold_tag", 128'(m_tag), 128'(hold_tag));
    end
    if (m_valid && m_ready) begin
      if (exp_data_q.size() == 0) begin
        check("unexpected_frame", 128'(m_valid), 128'(1'b0));
      end else begin
        check("frame_data", 128'(m_data), exp_data_q.pop_front());
        check("frame_err", 128'(m_err), 128'(exp_err_q.pop_front()));
        check("frame_tag", 128'(m_tag), 128'(exp_tag_q.pop_front()));
      end
    end
    hold_pending = m_valid && !m_ready;
    hold_data    = 128'(m_data);
    hold_err     = m_err;
    hold_tag     = m_tag;
    acc = s_valid && s_ready;
    if (acc) model_push(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    s_valid  = 1'b0;
    s_valid1 = 1'b0;
    rst      = 1'b1;
    #1;
    check("rst_m_valid", 128'(m_valid), 128'(1'b0));
    check("rst_m_data", 128'(m_data), 128'(0));
    check("rst_m_err", 128'(m_err), 128'(1'b0));
    check("rst_m_tag", 128'(m_tag), 128'(8'd0));
    check("rst_s_ready", 128'(s_ready), 128'(1'b1));
    check("rst_m_valid1", 128'(m_valid1), 128'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] smp   [8];
    logic [15:0] lanes [8];
    logic        err;
    logic [7:0]  tag;
    logic        dir;
  } vec_t;

  vec_t tbl [6];

  task automatic lanes_chk(input string pfx, input logic [127:0] data, input vec_t v);
    for (int i = 0; i < K; i++)
      check($sformatf("%s_lane%0d", pfx, i), 128'(data[i*16 +: 16]), 128'(v.lanes[i]));
  endtask

  task automatic apply0(input vec_t v, input int idx);
    logic acc;
    for (int j = 0; j < K; j++) begin
      int tries = 0;
      acc = 1'b0;
      while (!acc && tries < 4) begin
        cyc(1'b1, v.smp[j], 1'b1, acc);
        tries++;
      end
      if (!acc) check($sformatf("v%0d_accept", idx), 128'(acc), 128'(1'b1));
    end
    cyc(1'b0, 16'd0, 1'b1, acc);
    check($sformatf("v%0d_early", idx), 128'(m_valid), 128'(1'b0));
    cyc(1'b0, 16'd0, 1'b1, acc);
    check($sformatf("v%0d_valid", idx), 128'(m_valid), 128'(1'b1));
    lanes_chk($sformatf("v%0d", idx), 128'(m_data), v);
    check($sformatf("v%0d_err", idx), 128'(m_err), 128'(v.err));
    check($sformatf("v%0d_tag", idx), 128'(m_tag), 128'(v.tag));
    cyc(1'b0, 16'd0, 1'b1, acc);
    check($sformatf("v%0d_onecycle", idx), 128'(m_valid), 128'(1'b0));
  endtask

  task automatic apply1(input vec_t v, input int idx);
    for (int j = 0; j < K; j++) begin
      @(negedge clk);
      s_valid1 = 1'b1;
      s_data1  = v.smp[j];
      m_ready1 = 1'b1;
      #1;
      check($sformatf("v%0d_sready", idx), 128'(s_ready1), 128'(1'b1));
    end
    @(negedge clk);
    s_valid1 = 1'b0;
    #1;
    check($sformatf("v%0d_early", idx), 128'(m_valid1), 128'(1'b0));
    @(negedge clk);
    #1;
    check($sformatf("v%0d_valid", idx), 128'(m_valid1), 128'(1'b1));
    lanes_chk($sformatf("v%0d", idx), 128'(m_data1), v);
    check($sformatf("v%0d_err", idx), 128'(m_err1), 128'(v.err));
    check($sformatf("v%0d_tag", idx), 128'(m_tag1), 128'(v.tag));
    @(negedge clk);
    #1;
    check($sformatf("v%0d_onecycle", idx), 128'(m_valid1), 128'(1'b0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n;
    int   bound;
    int   cur;

    tbl[0].smp   = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd2, 16'd4, 16'd6, 16'd8};
    tbl[0].lanes = '{16'd1, 16'd3, 16'd5, 16'd7, 16'd8, 16'd6, 16'd4, 16'd2};
    tbl[0].err = 1'b0; tbl[0].tag = 8'd0; tbl[0].dir = 1'b0;
    tbl[1].smp   = '{16'hFFFD, 16'hFFFF, 16'd0, 16'hFFFE, 16'd5, 16'd5, 16'd9, 16'd10};
    tbl[1].lanes = '{16'hFFFD, 16'hFFFF, 16'd0, 16'hFFFE, 16'd10, 16'd9, 16'd5, 16'd5};
    tbl[1].err = 1'b1; tbl[1].tag = 8'd1; tbl[1].dir = 1'b0;
    tbl[2].smp   = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].lanes = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].err = 1'b0; tbl[2].tag = 8'd2; tbl[2].dir = 1'b0;
    tbl[3].smp   = '{16'd9, 16'd7, 16'd5, 16'd1, 16'd8, 16'd6, 16'd4, 16'd2};
    tbl[3].lanes = '{16'd9, 16'd7, 16'd5, 16'd1, 16'd2, 16'd4, 16'd6, 16'd8};
    tbl[3].err = 1'b0; tbl[3].tag = 8'd0; tbl[3].dir = 1'b1;
    tbl[4].smp   = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    tbl[4].lanes = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd8, 16'd7, 16'd6, 16'd5};
    tbl[4].err = 1'b1; tbl[4].tag = 8'd1; tbl[4].dir = 1'b1;
    tbl[5].smp   = '{16'd8, 16'd9, 16'd10, 16'd11, 16'd0, 16'd1, 16'd2, 16'd3};
    tbl[5].lanes = '{16'd8, 16'd9, 16'd10, 16'd11, 16'd3, 16'd2, 16'd1, 16'd0};
    tbl[5].err = 1'b0; tbl[5].tag = 8'd0; tbl[5].dir = 1'b0;

    model_reset();
    do_reset();

    // Directed vectors (entries 0..4), each DUT tags independently from 0.
    for (int i = 0; i < 5; i++) begin
      if (tbl[i].dir) apply1(tbl[i], i);
      else            apply0(tbl[i], i);
    end

    // Backpressure: exactly one extra frame loads, then s_ready drops.
    do_reset();
    n = 0;
    bound = 0;
    while (n < 16 && bound < 40) begin
      cyc(1'b1, 16'(n), 1'b0, acc);
      if (acc) n++;
      bound++;
    end
    check("bp_accepts", 128'(n), 128'(16));
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 16'd100, 1'b0, acc);
      check("bp_sready_low", 128'(s_ready), 128'(1'b0));
      check("bp_valid", 128'(m_valid), 128'(1'b1));
      check("bp_tag0", 128'(m_tag), 128'(8'd0));
    end
    cyc(1'b1, 16'd100, 1'b1, acc);
    cyc(1'b0, 16'd0, 1'b0, acc);
    check("bp_valid_next", 128'(m_valid), 128'(1'b1));
    check("bp_tag1", 128'(m_tag), 128'(8'd1));
    check("bp_sready_back", 128'(s_ready), 128'(1'b1));

    // Reset mid-frame discards the partial frame.
    do_reset();
    for (int j = 0; j < 3; j++) cyc(1'b1, 16'(50 + j), 1'b1, acc);
    do_reset();
    apply0(tbl[5], 5);

    // Streaming: 24 back-to-back samples with m_ready held high.
    do_reset();
    for (int c = 0; c < 24; c++) begin
      cyc(1'b1, 16'((c / 8) * 20 + (c % 8)), 1'b1, acc);
      check("stream_sready", 128'(s_ready), 128'(1'b1));
    end
    for (int c = 0; c < 4; c++) cyc(1'b0, 16'd0, 1'b1, acc);
    check("stream_frames", 128'(model_frames), 128'(3));
    check("stream_drained", 128'(exp_data_q.size()), 128'(0));

    // Random traffic long enough for the tag to wrap 255 -> 0.
    cur = 0;
    bound = 0;
    while (model_frames < 262 && bound < 20000) begin
      if ($urandom_range(0, 15) == 0) cur = int'($urandom_range(0, 200)) - 100;
      else                            cur = cur + int'($urandom_range(0, 3));
      cyc($urandom_range(0, 9) < 7, 16'(cur), $urandom_range(0, 9) < 6, acc);
      bound++;
    end
    check("rand_frames_reached", 128'(model_frames >= 262), 128'(1'b1));

    bound = 0;
    while (exp_data_q.size() != 0 && bound < 20) begin
      cyc(1'b0, 16'd0, 1'b1, acc);
      bound++;
    end
    cyc(1'b0, 16'd0, 1'b1, acc);
    check("final_drain", 128'(exp_data_q.size()), 128'(0));
    check("final_idle", 128'(m_valid), 128'(1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
